// File: rtl/bcd_updown_counter_display.sv
// Multi-digit BCD up/down counter with load, terminal-count pulse and a
// multiplexed, registered seven-segment driver (active-low AN/CA).
// Optional feature: define BCD_LZB_EN for leading-zero blanking.
module bcd_updown_counter_display #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned MOD_VALUE  = 10000,
  parameter int unsigned COUNT_DIV  = 100_000_000,
  parameter int unsigned SCAN_DIV   = 100_000
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic                    up_i,
  input  logic                    load_i,
  input  logic [4*NUM_DIGITS-1:0] load_val_i,
  output logic [4*NUM_DIGITS-1:0] count_o,
  output logic                    tc_o,
  output logic [7:0]              an_o,
  output logic [7:0]              ca_o
);

  localparam int unsigned W    = 4 * NUM_DIGITS;
  localparam int unsigned CntW = $clog2(COUNT_DIV);
  localparam int unsigned ScnW = $clog2(SCAN_DIV);

  // Elaboration-time binary to BCD conversion of the terminal value.
  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  t;
    r = '0;
    t = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  // Active-low {g,f,e,d,c,b,a} patterns for decimal digits.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  localparam logic [W-1:0] MaxBcd = to_bcd(MOD_VALUE - 1);

  logic [CntW-1:0] cdiv_q, cdiv_d;
  logic [ScnW-1:0] sdiv_q, sdiv_d;
  logic [2:0]      idx_q, idx_d;
  logic [W-1:0]    count_q, count_d;
  logic            tc_q, tc_d;
  logic [7:0]      an_q, an_d, ca_q, ca_d;
  logic            count_tick, scan_tick;
  logic [W-1:0]    load_bcd, inc_bcd, dec_bcd;
  logic            carry, borrow;
  logic [3:0]      digit;
  logic            blank;

  assign count_tick = (cdiv_q == CntW'(COUNT_DIV - 1));
  assign scan_tick  = (sdiv_q == ScnW'(SCAN_DIV - 1));

  // Free-running prescalers and scan index advance.
  always_comb begin
    cdiv_d = count_tick ? '0 : cdiv_q + CntW'(1);
    sdiv_d = scan_tick ? '0 : sdiv_q + ScnW'(1);
    idx_d  = idx_q;
    if (scan_tick) idx_d = (idx_q == 3'(NUM_DIGITS - 1)) ? 3'd0 : idx_q + 3'd1;
  end

  // Load sanitising plus ripple BCD increment/decrement of the current count.
  always_comb begin
    load_bcd = '0;
    inc_bcd  = count_q;
    dec_bcd  = count_q;
    carry    = 1'b1;
    borrow   = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_bcd[4*i +: 4] = (load_val_i[4*i +: 4] > 4'd9) ? 4'd0 : load_val_i[4*i +: 4];
      if (carry) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_bcd[4*i +: 4] = 4'd0;
        end else begin
          inc_bcd[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_bcd[4*i +: 4] = 4'd9;
        end else begin
          dec_bcd[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  // Count next state: load beats an enabled tick; wraps raise TC.
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    if (load_i) begin
      // BCD with valid digits orders the same as plain binary.
      count_d = (load_bcd > MaxBcd) ? '0 : load_bcd;
    end else if (count_tick && en_i) begin
      if (up_i) begin
        if (count_q == MaxBcd) begin
          count_d = '0;
          tc_d    = 1'b1;
        end else begin
          count_d = inc_bcd;
        end
      end else begin
        if (count_q == '0) begin
          count_d = MaxBcd;
          tc_d    = 1'b1;
        end else begin
          count_d = dec_bcd;
        end
      end
    end
  end

`ifdef BCD_LZB_EN
  logic [2:0] msd;
  // Most significant non-zero digit; digit 0 is never blanked.
  always_comb begin
    msd = 3'd0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (count_q[4*i +: 4] != 4'd0) msd = 3'(i);
    end
  end
  assign blank = (idx_q > msd);
`else
  assign blank = 1'b0;
`endif

  // Anode/segment decode from one index so both change on the same edge.
  always_comb begin
    digit = 4'd0;
    an_d  = 8'hFF;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        digit   = count_q[4*i +: 4];
        an_d[i] = 1'b0;
      end
    end
    ca_d = {1'b1, seg7(digit)};
    if (blank) begin
      an_d = 8'hFF;
      ca_d = 8'hFF;
    end
  end

  // State registers, all cleared asynchronously.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cdiv_q  <= '0;
      sdiv_q  <= '0;
      idx_q   <= 3'd0;
      count_q <= '0;
      tc_q    <= 1'b0;
      an_q    <= 8'hFF;
      ca_q    <= 8'hFF;
    end else begin
      cdiv_q  <= cdiv_d;
      sdiv_q  <= sdiv_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      an_q    <= an_d;
      ca_q    <= ca_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign an_o    = an_q;
  assign ca_o    = ca_q;

endmodule

// File: tb/tb_bcd_updown_counter_display.sv
// Bench for bcd_updown_counter_display: scoreboarded count stream plus
// directed display, reset and modulus-60 checks.
module tb_bcd_updown_counter_display;

  logic       clk = 1'b0;
  logic       rst;
  logic       en, up, load;
  logic [7:0] load_val, count;
  logic       tc;
  logic [7:0] an, ca;

  logic       en60, up60, load60;
  logic [7:0] load_val60, count60;
  logic       tc60;
  logic [7:0] an60, ca60;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [7:0] count;
    logic       tc;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic       mon_en = 1'b0;
  logic [7:0] prev_count = 8'h00;

  always #5 clk = ~clk;

  bcd_updown_counter_display #(
    .NUM_DIGITS(2), .MOD_VALUE(100), .COUNT_DIV(4), .SCAN_DIV(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .up_i(up), .load_i(load),
    .load_val_i(load_val), .count_o(count), .tc_o(tc), .an_o(an), .ca_o(ca)
  );

  bcd_updown_counter_display #(
    .NUM_DIGITS(2), .MOD_VALUE(60), .COUNT_DIV(4), .SCAN_DIV(2)
  ) dut60 (
    .clk_i(clk), .rst_i(rst), .en_i(en60), .up_i(up60), .load_i(load60),
    .load_val_i(load_val60), .count_o(count60), .tc_o(tc60), .an_o(an60), .ca_o(ca60)
  );

  task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] bcd8(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic push(input logic [7:0] c, input logic t);
    exp_t x;
    x.count = c;
    x.tc    = t;
    exp_q.push_back(x);
  endtask

  task automatic wait_empty(input int limit, input string nm);
    int i = 0;
    while (exp_q.size() != 0 && i < limit) begin
      @(negedge clk);
      #1;
      i++;
    end
    check1(nm, exp_q.size() == 0, 1'b1);
  endtask

  // Monitor: each count change pops one expected entry; otherwise TC must be low.
  always @(negedge clk) begin
    if (mon_en) begin
      if (count !== prev_count) begin
        if (exp_q.size() == 0) begin
          check8("unexpected_count_change", count, prev_count);
        end else begin
          e = exp_q.pop_front();
          check8("count_step", count, e.count);
          check1("tc_at_step", tc, e.tc);
        end
        prev_count = count;
      end else begin
        check1("tc_idle", tc, 1'b0);
      end
    end
  end

  logic [7:0] an_s[12];
  logic [7:0] ca_s[12];
  logic [7:0] d1_an, d1_ca;

  initial begin
    int t0;
    int n1;
    int cyc;
    logic [7:0] other;
    rst = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = 8'h00;
    en60 = 1'b0; up60 = 1'b1; load60 = 1'b0; load_val60 = 8'h00;
`ifdef BCD_LZB_EN
    d1_an = 8'hFF; d1_ca = 8'hFF;
`else
    d1_an = 8'hFD; d1_ca = 8'hC0;
`endif

    // Reset values while held in reset.
    repeat (3) @(posedge clk);
    #1;
    check8("rst_count", count, 8'h00);
    check1("rst_tc", tc, 1'b0);
    check8("rst_an", an, 8'hFF);
    check8("rst_ca", ca, 8'hFF);
    #2 rst = 1'b0;
    #1;
    check8("an_before_first_edge", an, 8'hFF);

    // Full up-count wrap: 01..99 then 00 with TC.
    en = 1'b1; up = 1'b1;
    prev_count = 8'h00;
    mon_en = 1'b1;
    for (int i = 1; i <= 100; i++) push(bcd8(i % 100), i == 100);
    wait_empty(600, "up_sequence_done");
    en = 1'b0;
    repeat (12) @(negedge clk);

    // Load 05 then count down through 00 to 99 with TC.
    load = 1'b1; load_val = 8'h05; up = 1'b0; en = 1'b1;
    push(8'h05, 1'b0);
    for (int i = 4; i >= 0; i--) push(bcd8(i), 1'b0);
    push(8'h99, 1'b1);
    @(posedge clk);
    #1 load = 1'b0;
    wait_empty(100, "down_sequence_done");
    en = 1'b0;

    // Load coincident with an enabled tick: load wins, no TC.
    repeat (3) @(posedge clk);
    #1;
    load = 1'b1; load_val = 8'h42; en = 1'b1; up = 1'b1;
    push(8'h42, 1'b0);
    @(posedge clk);
    #1;
    load = 1'b0; en = 1'b0;
    check8("load_vs_tick_count", count, 8'h42);
    check1("load_vs_tick_tc", tc, 1'b0);
    repeat (8) @(negedge clk);
    wait_empty(2, "load_vs_tick_done");

    // Display scan of 47.
    @(posedge clk);
    #1 load = 1'b1; load_val = 8'h47;
    push(8'h47, 1'b0);
    @(posedge clk);
    #1 load = 1'b0;
    wait_empty(10, "load47_done");
    repeat (5) @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      an_s[k] = an;
      ca_s[k] = ca;
    end
    for (int k = 0; k < 12; k++) begin
      check1("scan47_an_valid", (an_s[k] == 8'hFE) || (an_s[k] == 8'hFD), 1'b1);
      check8("scan47_ca", ca_s[k], (an_s[k] == 8'hFD) ? 8'h99 : 8'hF8);
    end
    t0 = -1;
    for (int k = 1; k < 12; k++) begin
      if (t0 < 0 && an_s[k] != an_s[k-1]) t0 = k;
    end
    check1("scan47_first_toggle", (t0 == 1) || (t0 == 2), 1'b1);
    if (t0 > 0) begin
      other = (an_s[t0] == 8'hFE) ? 8'hFD : 8'hFE;
      for (int k = t0; k < 12; k++) begin
        check8("scan47_hold2", an_s[k], (((k - t0) / 2) % 2 == 0) ? an_s[t0] : other);
      end
    end

    // Display of 07: digit 1 slot depends on leading-zero blanking.
    @(posedge clk);
    #1 load = 1'b1; load_val = 8'h07;
    push(8'h07, 1'b0);
    @(posedge clk);
    #1 load = 1'b0;
    wait_empty(10, "load07_done");
    repeat (5) @(posedge clk);
    n1 = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (an == 8'hFE) begin
        check8("scan07_d0_ca", ca, 8'hF8);
      end else begin
        check8("scan07_d1_an", an, d1_an);
        check8("scan07_d1_ca", ca, d1_ca);
        n1++;
      end
    end
    check8("scan07_d1_slots", 8'(n1), 8'd4);

    // Asynchronous reset mid-cycle at 33 with a load in flight.
    @(posedge clk);
    #1 load = 1'b1; load_val = 8'h33;
    push(8'h33, 1'b0);
    @(posedge clk);
    #1 load = 1'b0;
    wait_empty(10, "load33_done");
    @(posedge clk);
    #3;
    load = 1'b1; load_val = 8'h55;
    mon_en = 1'b0;
    #1 rst = 1'b1;
    #1;
    check8("async_rst_count", count, 8'h00);
    check1("async_rst_tc", tc, 1'b0);
    check8("async_rst_an", an, 8'hFF);
    check8("async_rst_ca", ca, 8'hFF);
    @(posedge clk);
    #1 load = 1'b0;
    #2 rst = 1'b0;
    #1;
    check8("rel_an_before_edge", an, 8'hFF);
    en = 1'b1; up = 1'b1;
    @(posedge clk);
    #1;
    check8("rel_edge1_an", an, 8'hFE);
    check8("rel_edge1_ca", ca, 8'hC0);
    check8("rel_edge1_count", count, 8'h00);
    for (cyc = 2; cyc <= 3; cyc++) begin
      @(posedge clk);
      #1 check8("rel_hold_count", count, 8'h00);
    end
    @(posedge clk);
    #1;
    check8("rel_first_step", count, 8'h01);
    en = 1'b0;

    // Modulus 60 instance: load sanitising, range clamp and wrap.
    @(posedge clk);
    #1 load60 = 1'b1; load_val60 = 8'h3C;
    @(posedge clk);
    #1 load60 = 1'b0;
    check8("m60_load_3c", count60, 8'h30);
    check1("m60_load_no_tc", tc60, 1'b0);
    load60 = 1'b1; load_val60 = 8'h72;
    @(posedge clk);
    #1 load60 = 1'b0;
    check8("m60_load_72", count60, 8'h00);
    load60 = 1'b1; load_val60 = 8'h59;
    @(posedge clk);
    #1 load60 = 1'b0;
    check8("m60_load_59", count60, 8'h59);
    en60 = 1'b1; up60 = 1'b1;
    cyc = 0;
    while (count60 == 8'h59 && cyc < 10) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check8("m60_wrap_count", count60, 8'h00);
    check1("m60_wrap_tc", tc60, 1'b1);
    @(posedge clk);
    #1;
    check1("m60_tc_one_cycle", tc60, 1'b0);
    en60 = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
